usbfs_link_ctrl: RTL and testbench
==================================

Name: usbfs_link_ctrl

Overview:
Parametrised USB Full Speed device link-state controller.
- Owns D+ pull-up control, power-on soft-disconnect timing, host bus-reset detection and suspend/resume detection.
- Generalises the fixed 60 MHz / 1000 ms / 300-cycle connect-reset logic to any clock frequency and configurable timings.
- Sits between the D+/D- pins and the bit/packet/transaction layers.
- Drives the layers' active-low usb_rstn and exports suspend/reset status to the application.

Parameters:
CLK_FREQ_HZ, 60000000, clk frequency in Hz.
DISCONNECT_MS, 1000, pull-up held off after reset or soft detach.
BUSRST_US, 5, consecutive SE0 time that is declared a host bus reset.
SUSPEND_MS, 3, consecutive idle-J time that is declared suspend.
WAKEUP_MS, 2, K-drive duration for remote wakeup (used only with the optional feature).

Ports:
clk  input  1  system clock, CLK_FREQ_HZ
rst  input  1  synchronous, active-high reset
usb_dp_rx  input  1  raw D+ pin level (asynchronous)
usb_dn_rx  input  1  raw D- pin level (asynchronous)
tx_active  input  1  high while the bit layer drives the bus (usb_oe)
soft_detach  input  1  level; high forces disconnect
wakeup_req  input  1  single-cycle remote-wakeup request
usb_dp_pull  output  1  enables the 1.5k D+ pull-up
usb_rstn  output  1  active-low reset to bit/packet/transaction layers
suspend  output  1  high while the bus is suspended
bus_reset_pulse  output  1  one-cycle strobe on bus-reset detection
line_state  output  2  synchronized {dp,dn}
wk_oe  output  1  wakeup drive enable, OR'd into the pad output enable
wk_dp  output  1  wakeup D+ value
wk_dn  output  1  wakeup D- value

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- Derived constants, integer arithmetic at elaboration:
  - DISC_CYC = CLK_FREQ_HZ/1000*DISCONNECT_MS
  - BRST_CYC = CLK_FREQ_HZ/1000000*BUSRST_US
  - SUSP_CYC = CLK_FREQ_HZ/1000*SUSPEND_MS
  - WAKE_CYC = CLK_FREQ_HZ/1000*WAKEUP_MS
  - Each must be ≥2; elaboration error otherwise.
  - One shared counter, width $clog2 of the largest constant, plus 1; it never wraps, and saturates at its target.
- Synchronizer: 2-flop on dp/dn; line_state is the second stage.
  - J = 10, K = 01, SE0 = 00; SE1 = 11 is treated as non-idle, non-SE0.
- Reset values: usb_dp_pull=0, usb_rstn=0, suspend=0, bus_reset_pulse=0, wk_oe=0, wk_dp=0, wk_dn=0, state=DISC, counter=0, synchronizer=00.
- All outputs are registered.
- States:
  - DISC:
    - pull=0, usb_rstn=0; counter increments.
    - Counter reaches DISC_CYC-1 → ATTACH.
  - ATTACH:
    - pull=1, usb_rstn=0.
    - First synchronized non-SE0 sample → ACTIVE; usb_rstn=1 the following cycle.
  - ACTIVE: pull=1, usb_rstn=1. The counter tracks the current run.
    - SE0 run: reaches BRST_CYC → BUS_RESET. bus_reset_pulse=1 for exactly that transition cycle; usb_rstn=0 the next cycle.
    - J run: reaches SUSP_CYC → SUSPEND.
    - Any line-state change restarts the counter at 0.
    - tx_active=1 holds the counter at 0 (own EOP/traffic is never reset or idle).
  - BUS_RESET:
    - usb_rstn=0; remains while SE0.
    - Non-SE0 → ACTIVE with counter=0.
  - SUSPEND:
    - suspend=1, usb_rstn=1.
    - Any non-J sample → ACTIVE, suspend=0 the next cycle. An SE0 resume that persists then becomes a bus reset through ACTIVE's SE0 counting.
- soft_detach=1 in any state → DISC next cycle with counter=0; it stays in DISC while asserted, and DISC_CYC timing starts on deassertion.
- Priority in the same cycle: rst > soft_detach > line-based transitions.
- rst mid-operation returns to DISC and restarts the full DISC_CYC interval.

Optional Feature:
USBFS_REMOTE_WAKEUP_EN
- Defined:
  - wakeup_req in SUSPEND → WAKE state.
  - wk_oe=1, wk_dp=0, wk_dn=1 (K) for exactly WAKE_CYC cycles; suspend stays 1.
  - Then wk_oe=0 → ACTIVE with counter=0.
  - Line samples are ignored while driving.
  - wakeup_req outside SUSPEND is ignored.
  - soft_detach aborts WAKE, dropping wk_oe the same cycle as entering DISC.
- Undefined: WAKE state absent; wakeup_req ignored; wk_oe, wk_dp, wk_dn constant 0.

Test Plan:
1. CLK_FREQ_HZ=1000000, DISCONNECT_MS=1, line J from t0, rst released at t0 → usb_dp_pull rises at cycle 1000 ±1; usb_rstn rises within 4 cycles after that.
2. ACTIVE, SE0 held 4 cycles (BUSRST_US=5) → no reset. SE0 held 5 cycles → bus_reset_pulse single cycle, usb_rstn=0 until J returns, then 1.
3. ACTIVE, J idle 3000 cycles (SUSPEND_MS=3) → suspend=1. Inject a K sample → suspend=0 within 4 cycles, usb_rstn stays 1.
4. ACTIVE with tx_active=1 while line shows SE0 for 10 cycles → no bus_reset_pulse, usb_rstn stays 1.
5. soft_detach asserted mid-ACTIVE for 3 cycles → usb_dp_pull=0 next cycle; pull returns 1000 cycles after deassert.
6. With USBFS_REMOTE_WAKEUP_EN, WAKEUP_MS=2, wakeup_req in SUSPEND → wk_oe=1, {wk_dp,wk_dn}=01 for exactly 2000 cycles, then suspend=0. Without the macro → wk_oe stays 0.

Source files
------------

// File: rtl/usbfs_link_ctrl.sv
`timescale 1ns/1ps
// usbfs_link_ctrl: USB FS device link state (pull-up, bus reset, suspend/resume).
// Define USBFS_REMOTE_WAKEUP_EN to add the remote-wakeup K drive (WAKE state).
module usbfs_link_ctrl #(
    parameter int CLK_FREQ_HZ   = 60000000,
    parameter int DISCONNECT_MS = 1000,
    parameter int BUSRST_US     = 5,
    parameter int SUSPEND_MS    = 3,
    parameter int WAKEUP_MS     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       usb_dp_rx,
    input  logic       usb_dn_rx,
    input  logic       tx_active,
    input  logic       soft_detach,
    input  logic       wakeup_req,
    output logic       usb_dp_pull,
    output logic       usb_rstn,
    output logic       suspend,
    output logic       bus_reset_pulse,
    output logic [1:0] line_state,
    output logic       wk_oe,
    output logic       wk_dp,
    output logic       wk_dn
);

    localparam int DISC_CYC = CLK_FREQ_HZ / 1000 * DISCONNECT_MS;
    localparam int BRST_CYC = CLK_FREQ_HZ / 1000000 * BUSRST_US;
    localparam int SUSP_CYC = CLK_FREQ_HZ / 1000 * SUSPEND_MS;
    localparam int WAKE_CYC = CLK_FREQ_HZ / 1000 * WAKEUP_MS;
    localparam int MAX_DS   = (DISC_CYC > SUSP_CYC) ? DISC_CYC : SUSP_CYC;
    localparam int MAX_BW   = (BRST_CYC > WAKE_CYC) ? BRST_CYC : WAKE_CYC;
    localparam int MAX_CYC  = (MAX_DS > MAX_BW) ? MAX_DS : MAX_BW;
    localparam int CW       = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] DISC_END = CW'(DISC_CYC - 1);
    localparam logic [CW-1:0] BRST_END = CW'(BRST_CYC - 1);
    localparam logic [CW-1:0] SUSP_END = CW'(SUSP_CYC - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(MAX_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b10;

    if (DISC_CYC < 2 || BRST_CYC < 2 || SUSP_CYC < 2 || WAKE_CYC < 2) begin : g_cfg_err
        $error("usbfs_link_ctrl: every derived cycle count must be >= 2");
    end

    typedef enum logic [2:0] {
        S_DISC,
        S_ATTACH,
        S_ACTIVE,
        S_BUS_RESET,
        S_SUSPEND
`ifdef USBFS_REMOTE_WAKEUP_EN
        ,
        S_WAKE
`endif
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [1:0]    sync1, sync2;
    logic          pulse_n, rstn_n, susp_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {usb_dp_rx, usb_dn_rx};
            sync2 <= sync1;
        end
    end

    assign line_state = sync2;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pulse_n = 1'b0;
        cnt_inc = (cnt >= CNT_SAT) ? cnt : cnt + CNT_ONE;
        unique case (state)
            S_DISC: begin
                if (cnt >= DISC_END) begin
                    state_n = S_ATTACH;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_ATTACH: begin
                if (sync2 != LS_SE0) begin
                    state_n = S_ACTIVE;
                    cnt_n   = '0;
                end
            end
            S_ACTIVE: begin
                // cnt holds (samples in the current line run) - 1
                if (tx_active) begin
                    cnt_n = '0;
                end else if (sync2 == LS_SE0 && cnt >= BRST_END) begin
                    state_n = S_BUS_RESET;
                    cnt_n   = '0;
                    pulse_n = 1'b1;
                end else if (sync2 == LS_J && cnt >= SUSP_END) begin
                    state_n = S_SUSPEND;
                    cnt_n   = '0;
                end else if (sync1 != sync2) begin
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_BUS_RESET: begin
                if (sync2 != LS_SE0) begin
                    state_n = S_ACTIVE;
                    cnt_n   = '0;
                end
            end
            S_SUSPEND: begin
                if (sync2 != LS_J) begin
                    state_n = S_ACTIVE;
                    cnt_n   = '0;
                end
`ifdef USBFS_REMOTE_WAKEUP_EN
                else if (wakeup_req) begin
                    state_n = S_WAKE;
                    cnt_n   = '0;
                end
`endif
            end
`ifdef USBFS_REMOTE_WAKEUP_EN
            S_WAKE: begin
                if (cnt >= CW'(WAKE_CYC - 1)) begin
                    state_n = S_ACTIVE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
`endif
            default: begin
                state_n = S_DISC;
                cnt_n   = '0;
            end
        endcase
        if (soft_detach) begin
            state_n = S_DISC;
            cnt_n   = '0;
            pulse_n = 1'b0;
        end
    end

`ifdef USBFS_REMOTE_WAKEUP_EN
    assign rstn_n = (state_n == S_ACTIVE) || (state_n == S_SUSPEND) ||
                    (state_n == S_WAKE);
    assign susp_n = (state_n == S_SUSPEND) || (state_n == S_WAKE);
`else
    assign rstn_n = (state_n == S_ACTIVE) || (state_n == S_SUSPEND);
    assign susp_n = (state_n == S_SUSPEND);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_DISC;
            cnt             <= '0;
            usb_dp_pull     <= 1'b0;
            usb_rstn        <= 1'b0;
            suspend         <= 1'b0;
            bus_reset_pulse <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            usb_dp_pull     <= (state_n != S_DISC);
            usb_rstn        <= rstn_n;
            suspend         <= susp_n;
            bus_reset_pulse <= pulse_n;
        end
    end

    // K drive is D+ low, D- high, so wk_dp never leaves 0
    assign wk_dp = 1'b0;

`ifdef USBFS_REMOTE_WAKEUP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wk_oe <= 1'b0;
            wk_dn <= 1'b0;
        end else begin
            wk_oe <= (state_n == S_WAKE);
            wk_dn <= (state_n == S_WAKE);
        end
    end
`else
    logic unused_wakeup;
    assign unused_wakeup = wakeup_req;
    assign wk_oe = 1'b0;
    assign wk_dn = 1'b0;
`endif

endmodule

// File: tb/tb_usbfs_link_ctrl.sv
`timescale 1ns/1ps
// tb_usbfs_link_ctrl: vector table, directed corner sequences and random
// line traffic against a run-length reference model of the link controller.
module tb_usbfs_link_ctrl;

    localparam int F_HZ = 1000000;
    localparam int D_MS = 1;
    localparam int B_US = 5;
    localparam int S_MS = 3;
    localparam int W_MS = 2;
    localparam int DISC_CYC = F_HZ / 1000 * D_MS;
    localparam int BRST_CYC = F_HZ / 1000000 * B_US;
    localparam int SUSP_CYC = F_HZ / 1000 * S_MS;
    localparam int WAKE_CYC = F_HZ / 1000 * W_MS;

    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_SE1 = 2'b11;

`ifdef USBFS_REMOTE_WAKEUP_EN
    localparam bit WK_EN = 1'b1;
`else
    localparam bit WK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dp = 1'b1;
    logic       dn = 1'b0;
    logic       tx_active = 1'b0;
    logic       soft_detach = 1'b0;
    logic       wakeup_req = 1'b0;
    logic       usb_dp_pull, usb_rstn, suspend, bus_reset_pulse;
    logic [1:0] line_state;
    logic       wk_oe, wk_dp, wk_dn;

    usbfs_link_ctrl #(
        .CLK_FREQ_HZ  (F_HZ),
        .DISCONNECT_MS(D_MS),
        .BUSRST_US    (B_US),
        .SUSPEND_MS   (S_MS),
        .WAKEUP_MS    (W_MS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .usb_dp_rx      (dp),
        .usb_dn_rx      (dn),
        .tx_active      (tx_active),
        .soft_detach    (soft_detach),
        .wakeup_req     (wakeup_req),
        .usb_dp_pull    (usb_dp_pull),
        .usb_rstn       (usb_rstn),
        .suspend        (suspend),
        .bus_reset_pulse(bus_reset_pulse),
        .line_state     (line_state),
        .wk_oe          (wk_oe),
        .wk_dp          (wk_dp),
        .wk_dn          (wk_dn)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act,
                             input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference model: link phases and run lengths of synchronized samples
    typedef enum int {M_OFF, M_WAIT, M_RUN, M_BRST, M_SLEEP, M_WAKE} mphase_t;
    mphase_t    m_ph = M_OFF;
    int         m_off = 0;
    int         m_run = 0;
    int         m_wake = 0;
    logic [1:0] m_run_ls = 2'b00;
    logic [1:0] m_q[$] = '{2'b00, 2'b00};
    logic [8:0] m_out = '0;

    task automatic model_step();
        logic [1:0] ls;
        logic       pulse;
        ls = m_q[0];
        pulse = 1'b0;
        if (rst) begin
            m_ph = M_OFF;
            m_off = 0;
            m_q = '{2'b00, 2'b00};
        end else begin
            void'(m_q.pop_front());
            m_q.push_back({dp, dn});
            if (soft_detach) begin
                m_ph = M_OFF;
                m_off = 0;
            end else begin
                case (m_ph)
                    M_OFF: begin
                        m_off++;
                        if (m_off == DISC_CYC) m_ph = M_WAIT;
                    end
                    M_WAIT: if (ls != LS_SE0) begin
                        m_ph = M_RUN;
                        m_run = 0;
                    end
                    M_RUN: begin
                        if (tx_active) begin
                            m_run = 0;
                        end else begin
                            m_run = (m_run > 0 && ls == m_run_ls) ? m_run + 1 : 1;
                            m_run_ls = ls;
                            if (ls == LS_SE0 && m_run >= BRST_CYC) begin
                                m_ph = M_BRST;
                                pulse = 1'b1;
                            end else if (ls == LS_J && m_run >= SUSP_CYC) begin
                                m_ph = M_SLEEP;
                            end
                        end
                    end
                    M_BRST: if (ls != LS_SE0) begin
                        m_ph = M_RUN;
                        m_run = 0;
                    end
                    M_SLEEP: begin
                        if (ls != LS_J) begin
                            m_ph = M_RUN;
                            m_run = 0;
                        end else if (WK_EN && wakeup_req) begin
                            m_ph = M_WAKE;
                            m_wake = 0;
                        end
                    end
                    M_WAKE: begin
                        m_wake++;
                        if (m_wake == WAKE_CYC) begin
                            m_ph = M_RUN;
                            m_run = 0;
                        end
                    end
                    default: m_ph = M_OFF;
                endcase
            end
        end
        m_out = {m_ph != M_OFF,
                 m_ph == M_RUN || m_ph == M_SLEEP || m_ph == M_WAKE,
                 m_ph == M_SLEEP || m_ph == M_WAKE,
                 pulse,
                 m_ph == M_WAKE, 1'b0, m_ph == M_WAKE,
                 m_q[0]};
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        check("model", {usb_dp_pull, usb_rstn, suspend, bus_reset_pulse,
                        wk_oe, wk_dp, wk_dn, line_state}, m_out);
        if (bus_reset_pulse) pulse_cnt++;
    endtask

    task automatic set_line(input logic [1:0] v);
        {dp, dn} = v;
    endtask

    task automatic wait_pull(input string name);
        int k;
        k = 0;
        while (!usb_dp_pull && k < DISC_CYC + 100) begin
            tick();
            k++;
        end
        check_rng(name, k, DISC_CYC - 1, DISC_CYC + 1);
    endtask

    typedef struct {
        logic [1:0] ls;
        logic       tx;
        logic       det;
        int         n;
        logic       e_pull;
        logic       e_rstn;
        logic       e_susp;
        int         e_pulses;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl[NV];

    initial begin
        int k, bad, on;
        tbl[0]  = '{LS_J,   1'b0, 1'b0, 10,   1'b1, 1'b1, 1'b0, 0};
        tbl[1]  = '{LS_SE0, 1'b0, 1'b0, 4,    1'b1, 1'b1, 1'b0, 0};
        tbl[2]  = '{LS_J,   1'b0, 1'b0, 10,   1'b1, 1'b1, 1'b0, 0};
        tbl[3]  = '{LS_SE0, 1'b0, 1'b0, 20,   1'b1, 1'b0, 1'b0, 1};
        tbl[4]  = '{LS_J,   1'b0, 1'b0, 10,   1'b1, 1'b1, 1'b0, 0};
        tbl[5]  = '{LS_K,   1'b0, 1'b0, 10,   1'b1, 1'b1, 1'b0, 0};
        tbl[6]  = '{LS_SE0, 1'b1, 1'b0, 10,   1'b1, 1'b1, 1'b0, 0};
        tbl[7]  = '{LS_J,   1'b0, 1'b0, 10,   1'b1, 1'b1, 1'b0, 0};
        tbl[8]  = '{LS_SE1, 1'b0, 1'b0, 10,   1'b1, 1'b1, 1'b0, 0};
        tbl[9]  = '{LS_J,   1'b0, 1'b1, 1,    1'b0, 1'b0, 1'b0, 0};
        tbl[10] = '{LS_J,   1'b0, 1'b1, 2,    1'b0, 1'b0, 1'b0, 0};
        tbl[11] = '{LS_J,   1'b0, 1'b0, 999,  1'b0, 1'b0, 1'b0, 0};
        tbl[12] = '{LS_J,   1'b0, 1'b0, 1,    1'b1, 1'b0, 1'b0, 0};
        tbl[13] = '{LS_J,   1'b0, 1'b0, 4,    1'b1, 1'b1, 1'b0, 0};
        tbl[14] = '{LS_J,   1'b0, 1'b0, 2990, 1'b1, 1'b1, 1'b0, 0};
        tbl[15] = '{LS_J,   1'b0, 1'b0, 10,   1'b1, 1'b1, 1'b1, 0};
        tbl[16] = '{LS_K,   1'b0, 1'b0, 10,   1'b1, 1'b1, 1'b0, 0};

        // reset state and power-on connect timing, line J from the start
        set_line(LS_J);
        repeat (3) tick();
        check("reset_outputs", {usb_dp_pull, usb_rstn, suspend, bus_reset_pulse,
                                wk_oe, wk_dp, wk_dn, line_state}, 9'd0);
        rst = 1'b0;
        wait_pull("connect_time");
        k = 0;
        while (!usb_rstn && k < 8) begin
            tick();
            k++;
        end
        check_rng("rstn_after_attach", k, 0, 4);
        repeat (10) tick();

        for (int i = 0; i < NV; i++) begin
            set_line(tbl[i].ls);
            tx_active = tbl[i].tx;
            soft_detach = tbl[i].det;
            pulse_cnt = 0;
            repeat (tbl[i].n) tick();
            check($sformatf("vec%0d_pull", i), usb_dp_pull, tbl[i].e_pull);
            check($sformatf("vec%0d_rstn", i), usb_rstn, tbl[i].e_rstn);
            check($sformatf("vec%0d_susp", i), suspend, tbl[i].e_susp);
            check($sformatf("vec%0d_pulses", i), pulse_cnt, tbl[i].e_pulses);
        end

        // SE0 for exactly the bus-reset time: one strobe, rstn low with it
        set_line(LS_SE0);
        pulse_cnt = 0;
        bad = 0;
        repeat (5) tick();
        set_line(LS_J);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus_reset_pulse && usb_rstn) bad++;
        end
        check("se0_5_pulses", pulse_cnt, 1);
        check("se0_5_rstn_at_pulse", bad, 0);
        check("se0_5_rstn_after", usb_rstn, 1);

        repeat (SUSP_CYC + 5) tick();
        check("suspend_entry", suspend, 1);

`ifdef USBFS_REMOTE_WAKEUP_EN
        wakeup_req = 1'b1;
        tick();
        wakeup_req = 1'b0;
        on = wk_oe ? 1 : 0;
        bad = 0;
        k = 0;
        while (wk_oe && k < WAKE_CYC + 100) begin
            if ({wk_dp, wk_dn} != 2'b01 || !suspend) bad++;
            tick();
            k++;
            if (wk_oe) on++;
        end
        check("wake_len", on, WAKE_CYC);
        check("wake_drive", bad, 0);
        check("wake_exit_susp", suspend, 0);

        repeat (SUSP_CYC + 5) tick();
        check("suspend_again", suspend, 1);
        wakeup_req = 1'b1;
        tick();
        wakeup_req = 1'b0;
        repeat (100) tick();
        soft_detach = 1'b1;
        tick();
        check("wake_abort_oe", wk_oe, 0);
        check("wake_abort_pull", usb_dp_pull, 0);
        soft_detach = 1'b0;
        repeat (DISC_CYC + 10) tick();
        repeat (SUSP_CYC + 5) tick();
        check("suspend_third", suspend, 1);
`else
        on = 0;
        wakeup_req = 1'b1;
        tick();
        wakeup_req = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (wk_oe) on++;
        end
        check("no_wake_oe", on, 0);
        check("no_wake_susp", suspend, 1);
`endif

        // resume by K: suspend drops quickly, usb_rstn never drops
        set_line(LS_K);
        k = 0;
        bad = 0;
        while (suspend && k < 10) begin
            tick();
            k++;
            if (!usb_rstn) bad++;
        end
        check_rng("resume_latency", k, 1, 4);
        check("resume_rstn", bad, 0);

        // random line traffic with occasional tx, detach and wakeup requests
        k = 0;
        while (k < 3000) begin
            int r, len;
            r = $urandom_range(0, 99);
            if (r < 40) set_line(LS_J);
            else if (r < 60) set_line(LS_K);
            else if (r < 90) set_line(LS_SE0);
            else set_line(LS_SE1);
            tx_active = ($urandom_range(0, 99) < 15);
            soft_detach = ($urandom_range(0, 199) == 0);
            wakeup_req = ($urandom_range(0, 49) == 0);
            len = $urandom_range(1, 8);
            repeat (len) tick();
            k += len;
        end
        tx_active = 1'b0;
        soft_detach = 1'b0;
        wakeup_req = 1'b0;
        set_line(LS_J);

        // reset mid-operation restarts the full disconnect interval
        rst = 1'b1;
        repeat (2) tick();
        check("mid_reset_outputs", {usb_dp_pull, usb_rstn, suspend,
                                    bus_reset_pulse, wk_oe}, 5'd0);
        rst = 1'b0;
        wait_pull("reconnect_time");
        repeat (5) tick();
        check("reconnect_rstn", usb_rstn, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
